// File: rtl/draw_pair_writer_if.sv
// Bundle of control, pair-handshake and RAM write-port signals for draw_pair_writer.
// Latency: none (pure wiring).
// Backpressure: in_valid/in_ready; in_ready is driven by the slave side.
interface draw_pair_writer_if #(
  parameter int DW = 8
);
  logic          start;
  logic [DW-1:0] color;
  logic          in_valid;
  logic          in_ready;
  logic [13:0]   in_addr_a;
  logic [13:0]   in_addr_b;
  logic          ram_we_a;
  logic          ram_we_b;
  logic [13:0]   ram_addr_a;
  logic [13:0]   ram_addr_b;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_din_b;
  logic [10:0]   pair_count;
  logic          done;
  logic          err;

  // Producer of start/color/address pairs; consumer of RAM writes and status.
  modport master (
    output start, color, in_valid, in_addr_a, in_addr_b,
    input  in_ready, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b,
    input  ram_din_a, ram_din_b, pair_count, done, err
  );

  // The fill writer itself.
  modport slave (
    input  start, color, in_valid, in_addr_a, in_addr_b,
    output in_ready, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b,
    output ram_din_a, ram_din_b, pair_count, done, err
  );
endinterface

// File: rtl/draw_pair_writer.sv
// Fills a dual-port RAM with a latched colour, one even/odd address pair per write.
// Latency: 1 cycle from pair acceptance to the registered write pulse on both ports.
// Backpressure: in_ready high only in RUN; pairs offered in IDLE/DONE are ignored.
module draw_pair_writer #(
  parameter int PAIRS = 1024,
  parameter int DW    = 8
) (
  input logic           clk,
  input logic           reset,
  draw_pair_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [10:0] LAST_CNT = 11'(PAIRS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_good;
  logic          w_wr;
  logic          w_start_acc;
  logic [13:0]   w_addr_a_inc;

  logic          r_we;
  logic [13:0]   r_addr_a;
  logic [13:0]   r_addr_b;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_color;
  logic [10:0]   r_pair_count;
  logic          r_done;
  logic          r_err;

  // Pair qualification: a pair is good only when a is even and b is exactly a+1.
  assign w_addr_a_inc = bus.in_addr_a + 14'd1;
  assign w_good       = ~bus.in_addr_a[0] && (bus.in_addr_b == w_addr_a_inc);
  assign w_accept     = w_in_ready && bus.in_valid;
  assign w_wr         = w_accept && w_good;
  // start is honoured outside RUN only, so a stray pulse mid-run keeps the colour.
  assign w_start_acc  = bus.start && (r_state != RUN);

  // Next-state decode and in_ready, which is the only combinational output.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = RUN;
      end
      RUN: begin
        w_in_ready = 1'b1;
        if (w_wr && (r_pair_count == LAST_CNT)) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // RAM write port: one-cycle pulse per good pair; address/data only move on a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_din    <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr_a <= bus.in_addr_a;
        r_addr_b <= bus.in_addr_b;
        r_din    <= r_color;
      end
    end
  end

  // Run bookkeeping: colour latch, pair count, sticky error, done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_color      <= '0;
      r_pair_count <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_color      <= bus.color;
        r_pair_count <= '0;
        r_err        <= 1'b0;
      end else begin
        if (w_wr)               r_pair_count <= r_pair_count + 11'd1;
        if (w_accept && !w_good) r_err       <= 1'b1;
      end
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.ram_we_a   = r_we;
  assign bus.ram_we_b   = r_we;
  assign bus.ram_addr_a = r_addr_a;
  assign bus.ram_addr_b = r_addr_b;
  assign bus.ram_din_a  = r_din;
  assign bus.ram_din_b  = r_din;
  assign bus.pair_count = r_pair_count;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_draw_pair_writer.sv
// Bench for draw_pair_writer: directed table for the first run, model-checked streams after.
// Latency: outputs compared on the falling edge after each driven rising edge.
// Backpressure: exercised through IDLE/DONE valid-ignore and gapped in_valid.
module tb_draw_pair_writer;

  localparam int PAIRS = 1024;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   n_wr;

  // Reference model state: 0 IDLE, 1 RUN, 2 DONE.
  int         m_state;
  int         m_cnt;
  bit         m_err;
  logic [7:0] m_color;

  draw_pair_writer_if #(.DW(8)) bus ();

  draw_pair_writer #(.PAIRS(PAIRS), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [7:0]  col;
    bit          v;
    logic [13:0] a;
    logic [13:0] b;
    bit          e_we;
    logic [7:0]  e_din;
    logic [10:0] e_cnt;
    bit          e_done;
    bit          e_err;
    bit          e_rdy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit st, input logic [7:0] col, input bit v,
                      input logic [13:0] a, input logic [13:0] b);
    bit         acc;
    bit         good;
    bit         ewe;
    logic [7:0] edin;
    bus.start     = st;
    bus.color     = col;
    bus.in_valid  = v;
    bus.in_addr_a = a;
    bus.in_addr_b = b;
    acc  = v && (m_state == 1);
    good = (a[0] == 1'b0) && (b == a + 14'd1);
    ewe  = acc && good;
    edin = m_color;
    if (st && m_state != 1) begin
      m_state = 1;
      m_color = col;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else if (m_state == 1) begin
      if (ewe) begin
        m_cnt++;
        if (m_cnt == PAIRS) m_state = 2;
      end
      if (acc && !good) m_err = 1'b1;
    end
    cyc();
    if (bus.ram_we_a === 1'b1) n_wr++;
    chk("we_a", 32'(bus.ram_we_a), 32'(ewe));
    chk("we_b", 32'(bus.ram_we_b), 32'(ewe));
    if (ewe) begin
      chk("addr_a", 32'(bus.ram_addr_a), 32'(a));
      chk("addr_b", 32'(bus.ram_addr_b), 32'(b));
      chk("din_a", 32'(bus.ram_din_a), 32'(edin));
      chk("din_b", 32'(bus.ram_din_b), 32'(edin));
    end
    chk("pair_count", 32'(bus.pair_count), 32'(m_cnt));
    chk("done", 32'(bus.done), 32'(m_state == 2));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we_a"}, 32'(bus.ram_we_a), 32'd0);
    chk({tag, "_we_b"}, 32'(bus.ram_we_b), 32'd0);
    chk({tag, "_addr_a"}, 32'(bus.ram_addr_a), 32'd0);
    chk({tag, "_addr_b"}, 32'(bus.ram_addr_b), 32'd0);
    chk({tag, "_din_a"}, 32'(bus.ram_din_a), 32'd0);
    chk({tag, "_din_b"}, 32'(bus.ram_din_b), 32'd0);
    chk({tag, "_count"}, 32'(bus.pair_count), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    logic [13:0] a;
    n_chk  = 0;
    n_fail = 0;
    n_wr   = 0;

    // st col   v  a      b      we din    cnt done err rdy
    tbl[0] = '{0, 8'h00, 1, 14'd10,   14'd11,   0, 8'h00, 11'd0, 0, 0, 0};
    tbl[1] = '{1, 8'hA5, 0, 14'd0,    14'd0,    0, 8'h00, 11'd0, 0, 0, 1};
    tbl[2] = '{0, 8'h00, 1, 14'd4096, 14'd4097, 1, 8'hA5, 11'd1, 0, 0, 1};
    tbl[3] = '{0, 8'h00, 1, 14'd4100, 14'd4102, 0, 8'h00, 11'd1, 0, 1, 1};
    tbl[4] = '{1, 8'hFF, 1, 14'd4098, 14'd4099, 1, 8'hA5, 11'd2, 0, 1, 1};
    tbl[5] = '{0, 8'h00, 1, 14'd4101, 14'd4102, 0, 8'h00, 11'd2, 0, 1, 1};
    tbl[6] = '{0, 8'h00, 0, 14'd4102, 14'd4103, 0, 8'h00, 11'd2, 0, 1, 1};
    tbl[7] = '{0, 8'h00, 1, 14'd4102, 14'd4103, 1, 8'hA5, 11'd3, 0, 1, 1};

    bus.start     = 1'b0;
    bus.color     = '0;
    bus.in_valid  = 1'b0;
    bus.in_addr_a = '0;
    bus.in_addr_b = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed opening of run 1 (colour A5), including a malformed pair and ignored start.
    for (int i = 0; i < 8; i++) begin
      bus.start     = tbl[i].st;
      bus.color     = tbl[i].col;
      bus.in_valid  = tbl[i].v;
      bus.in_addr_a = tbl[i].a;
      bus.in_addr_b = tbl[i].b;
      cyc();
      chk($sformatf("t%0d_we_a", i), 32'(bus.ram_we_a), 32'(tbl[i].e_we));
      chk($sformatf("t%0d_we_b", i), 32'(bus.ram_we_b), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("t%0d_addr_a", i), 32'(bus.ram_addr_a), 32'(tbl[i].a));
        chk($sformatf("t%0d_addr_b", i), 32'(bus.ram_addr_b), 32'(tbl[i].b));
        chk($sformatf("t%0d_din_a", i), 32'(bus.ram_din_a), 32'(tbl[i].e_din));
        chk($sformatf("t%0d_din_b", i), 32'(bus.ram_din_b), 32'(tbl[i].e_din));
      end
      chk($sformatf("t%0d_count", i), 32'(bus.pair_count), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_done", i), 32'(bus.done), 32'(tbl[i].e_done));
      chk($sformatf("t%0d_err", i), 32'(bus.err), 32'(tbl[i].e_err));
      chk($sformatf("t%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;

    // Finish run 1 back-to-back: pairs 3..1023, last a = 6142.
    m_state = 1;
    m_cnt   = 3;
    m_err   = 1'b1;
    m_color = 8'hA5;
    n_wr    = 3;
    for (int k = 3; k < PAIRS; k++) begin
      a = 14'(4096 + 2 * k);
      step(0, 8'h00, 1, a, a + 14'd1);
    end
    chk("run1_writes", 32'(n_wr), 32'd1024);
    chk("run1_count", 32'(bus.pair_count), 32'd1024);
    chk("run1_done", 32'(bus.done), 32'd1);
    chk("run1_in_ready", 32'(bus.in_ready), 32'd0);
    // Pairs offered in DONE are dropped silently.
    step(0, 8'h00, 1, 14'd6144, 14'd6145);
    step(0, 8'h00, 1, 14'd6145, 14'd6145);

    // Run 2: restart from DONE with 3C, gapped valid, stray start mid-run.
    n_wr = 0;
    step(1, 8'h3C, 0, 14'd0, 14'd0);
    for (int k = 0; k < PAIRS; k++) begin
      a = 14'(4096 + 2 * k);
      step(0, 8'h00, 1, a, a + 14'd1);
      step(k == 10, 8'h77, 0, a, a + 14'd1);
      step(0, 8'h00, 0, 14'd0, 14'd0);
    end
    chk("run2_writes", 32'(n_wr), 32'd1024);
    chk("run2_count", 32'(bus.pair_count), 32'd1024);

    // Run 3: abort with reset after 500 pairs.
    step(1, 8'h5A, 0, 14'd0, 14'd0);
    for (int k = 0; k < 500; k++) begin
      a = 14'(4096 + 2 * k);
      step(0, 8'h00, 1, a, a + 14'd1);
    end
    chk("pre_abort_we", 32'(bus.ram_we_a), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_addr_a = 14'd5096;
    bus.in_addr_b = 14'd5097;
    #2 reset = 1'b0;
    #1 chk_all_zero("abort");
    @(posedge clk);
    #1 chk("abort_edge_we_a", 32'(bus.ram_we_a), 32'd0);
    chk("abort_edge_we_b", 32'(bus.ram_we_b), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    m_state = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_color = 8'h00;
    // After release: stay in IDLE, valid ignored until start.
    for (int k = 0; k < 3; k++) begin
      a = 14'(5096 + 2 * k);
      step(0, 8'h00, 1, a, a + 14'd1);
    end
    step(1, 8'hC3, 0, 14'd0, 14'd0);
    step(0, 8'h00, 1, 14'd100, 14'd101);
    step(0, 8'h00, 1, 14'd102, 14'd103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
